// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I datapath: sequences fetch/decode/execute/memory/writeback,
// drives every mux select and write enable, stalls on mem_ready, traps on unknown opcodes, counts retirements.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       op,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       imm_src,
  output logic             reg_write,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_o
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_LUI      = 4'd8;
  localparam logic [3:0] S_ALUWB    = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JAL      = 4'd11;
  localparam logic [3:0] S_JALR     = 4'd12;
  localparam logic [3:0] S_JLINK    = 4'd13;
  localparam logic [3:0] S_TRAP     = 4'd14;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instret;
  logic             w_retire;
  logic             w_pc_update;
  logic             w_branch;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = S_EXECR;
          OP_I:              w_next = S_EXECI;
          OP_B:              w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
          OP_LUI:            w_next = S_LUI;
          OP_AUIPC:          w_next = S_ALUWB;
          default:           w_next = S_TRAP;
        endcase
      end
      S_MEMADR:   w_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
      S_EXECR, S_EXECI, S_LUI, S_JAL, S_JLINK: w_next = S_ALUWB;
      S_ALUWB, S_BRANCH: w_next = S_FETCH;
      S_JALR:     w_next = S_JLINK;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  // Only completed instructions return to FETCH from these states; a trap never does.
  assign w_retire = (w_next == S_FETCH) &&
                    (r_state inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= r_illegal | (w_next == S_TRAP);
      if (w_retire) r_instret <= r_instret + CNT_W'(1);
    end
  end

  always_comb begin
    adr_src     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    reg_write   = 1'b0;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read    = 1'b1;
        alu_src_b   = 2'b10;
        result_src  = 2'b10;
        ir_write    = mem_ready;
        w_pc_update = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_LUI: begin
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        w_branch  = 1'b1;
      end
      S_JAL: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        w_pc_update = 1'b1;
      end
      S_JALR: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        result_src  = 2'b10;
        w_pc_update = 1'b1;
      end
      S_JLINK: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE:         imm_src = 3'b001;
      OP_B:             imm_src = 3'b010;
      OP_JAL:           imm_src = 3'b011;
      OP_LUI, OP_AUIPC: imm_src = 3'b100;
      default:          imm_src = 3'b000;
    endcase
  end

  assign pc_write      = w_pc_update | (w_branch & branch_taken);
  assign illegal_instr = r_illegal;
  assign instret       = r_instret;
  assign state_o       = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: an instruction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized op/mem_ready/branch_taken traffic.
module tb_multicycle_controller;

  localparam int CW = 4;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_FENCE = 7'b0001111;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [6:0]    op = OP_I;
  logic          branchTaken = 1'b0;
  logic          memReady = 1'b0;
  logic          pcWrite, adrSrc, memRead, memWrite, irWrite, regWrite, illegalInstr;
  logic [1:0]    resultSrc, aluSrcA, aluSrcB, aluOp;
  logic [2:0]    immSrc;
  logic [CW-1:0] instret;
  logic [3:0]    stateO;

  int compared = 0;
  int mismatched = 0;

  multicycle_controller #(.CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .branch_taken(branchTaken), .mem_ready(memReady),
    .pc_write(pcWrite), .adr_src(adrSrc), .mem_read(memRead), .mem_write(memWrite),
    .ir_write(irWrite), .result_src(resultSrc), .alu_src_a(aluSrcA), .alu_src_b(aluSrcB),
    .alu_op(aluOp), .imm_src(immSrc), .reg_write(regWrite), .illegal_instr(illegalInstr),
    .instret(instret), .state_o(stateO)
  );

  always #5 clk = ~clk;

  // Phases are listed in the same order as the debug state codes.
  typedef enum int {
    P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE, P_EXECR, P_EXECI,
    P_LUI, P_ALUWB, P_BRANCH, P_JAL, P_JALR, P_JLINK, P_TRAP
  } phase_t;

  typedef struct packed {
    logic       pcWrite;
    logic       adrSrc;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [2:0] immSrc;
    logic       regWrite;
  } ctl_t;

  phase_t mPhase = P_FETCH;
  phase_t mRest[$];
  int     mInstret = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic ctl_t expected(phase_t p, logic [6:0] o, logic mr, logic bt);
    ctl_t e = '0;
    case (o)
      OP_STORE:         e.immSrc = 3'b001;
      OP_B:             e.immSrc = 3'b010;
      OP_JAL:           e.immSrc = 3'b011;
      OP_LUI, OP_AUIPC: e.immSrc = 3'b100;
      default:          e.immSrc = 3'b000;
    endcase
    case (p)
      P_FETCH:    begin e.memRead = 1; e.aluSrcB = 2'b10; e.resultSrc = 2'b10; e.irWrite = mr; e.pcWrite = mr; end
      P_DECODE:   begin e.aluSrcA = 2'b01; e.aluSrcB = 2'b01; end
      P_MEMADR:   begin e.aluSrcA = 2'b10; e.aluSrcB = 2'b01; end
      P_MEMREAD:  begin e.adrSrc = 1; e.memRead = 1; end
      P_MEMWB:    begin e.resultSrc = 2'b01; e.regWrite = 1; end
      P_MEMWRITE: begin e.adrSrc = 1; e.memWrite = 1; end
      P_EXECR:    begin e.aluSrcA = 2'b10; e.aluOp = 2'b10; end
      P_EXECI:    begin e.aluSrcA = 2'b10; e.aluSrcB = 2'b01; e.aluOp = 2'b10; end
      P_LUI:      begin e.aluSrcB = 2'b01; e.aluOp = 2'b11; end
      P_ALUWB:    e.regWrite = 1;
      P_BRANCH:   begin e.aluSrcA = 2'b10; e.aluOp = 2'b01; e.pcWrite = bt; end
      P_JAL:      begin e.aluSrcA = 2'b01; e.aluSrcB = 2'b10; e.pcWrite = 1; end
      P_JALR:     begin e.aluSrcA = 2'b10; e.aluSrcB = 2'b01; e.resultSrc = 2'b10; e.pcWrite = 1; end
      P_JLINK:    begin e.aluSrcA = 2'b01; e.aluSrcB = 2'b10; end
      default:    ;
    endcase
    return e;
  endfunction

  // Reference model: each instruction is the list of phases that follow DECODE.
  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      mPhase = P_FETCH;
      mRest.delete();
      mInstret = 0;
    end else if (mPhase == P_FETCH) begin
      if (memReady) begin
        case (op)
          OP_LOAD:  mRest = {P_MEMADR, P_MEMREAD, P_MEMWB};
          OP_STORE: mRest = {P_MEMADR, P_MEMWRITE};
          OP_R:     mRest = {P_EXECR, P_ALUWB};
          OP_I:     mRest = {P_EXECI, P_ALUWB};
          OP_B:     mRest = {P_BRANCH};
          OP_JAL:   mRest = {P_JAL, P_ALUWB};
          OP_JALR:  mRest = {P_JALR, P_JLINK, P_ALUWB};
          OP_LUI:   mRest = {P_LUI, P_ALUWB};
          OP_AUIPC: mRest = {P_ALUWB};
          default:  mRest = {P_TRAP};
        endcase
        mPhase = P_DECODE;
      end
    end else if (mPhase != P_TRAP) begin
      if (!((mPhase == P_MEMREAD || mPhase == P_MEMWRITE) && !memReady)) begin
        if (mRest.size() == 0) begin
          mPhase = P_FETCH;
          mInstret = (mInstret + 1) % (1 << CW);
        end else begin
          mPhase = mRest.pop_front();
        end
      end
    end
  end

  initial forever begin
    ctl_t act;
    @(negedge clk);
    act = {pcWrite, adrSrc, memRead, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB, aluOp, immSrc, regWrite};
    checkOutput("controls", 64'(act), 64'(expected(mPhase, op, memReady, branchTaken)));
    checkOutput("state_o", 64'(stateO), 64'(int'(mPhase)));
    checkOutput("instret", 64'(instret), 64'(mInstret));
    checkOutput("illegal_instr", 64'(illegalInstr), 64'(mPhase == P_TRAP));
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH back to FETCH with the requested stall counts.
  task automatic applyStimulus(input logic [6:0] opc, input int fStall, input int mStall, input logic bt,
                               output int cycles, output int nReg, output int nPc,
                               output int nMemW, output int nIr);
    int  fl = fStall;
    int  ml = mStall;
    bit  left = 0;
    op = opc;
    branchTaken = bt;
    cycles = 0; nReg = 0; nPc = 0; nMemW = 0; nIr = 0;
    for (int k = 0; k < 60; k++) begin
      if (stateO == 4'd0 && fl > 0) begin
        memReady = 0; fl--;
      end else if ((stateO == 4'd3 || stateO == 4'd5) && ml > 0) begin
        memReady = 0; ml--;
      end else begin
        memReady = 1;
      end
      #1;
      cycles++;
      nReg += int'(regWrite); nPc += int'(pcWrite); nMemW += int'(memWrite); nIr += int'(irWrite);
      stepCycle();
      if (stateO != 4'd0) left = 1;
      else if (left) return;
    end
    compared++;
    mismatched++;
    $display("[TB] FAIL timeout op=%b: instruction did not return to FETCH in 60 cycles", opc);
  endtask

  initial begin
    int cyc, nReg, nPc, nMemW, nIr, enSum, trapCnt;
    logic [6:0] legalOps[9];
    legalOps = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_B, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset state_o", 64'(stateO), 64'd0);
    checkOutput("reset instret", 64'(instret), 64'd0);
    checkOutput("reset illegal", 64'(illegalInstr), 64'd0);
    checkOutput("reset mem_read", 64'(memRead), 64'd1);
    checkOutput("reset pc_write", 64'(pcWrite), 64'd0);
    reset_n = 1;
    stepCycle();

    applyStimulus(OP_LOAD, 2, 2, 0, cyc, nReg, nPc, nMemW, nIr);
    checkOutput("lw cycles", 64'(cyc), 64'd9);
    checkOutput("lw ir_write count", 64'(nIr), 64'd1);
    checkOutput("lw reg_write count", 64'(nReg), 64'd1);
    checkOutput("lw instret", 64'(instret), 64'd1);

    applyStimulus(OP_STORE, 0, 0, 0, cyc, nReg, nPc, nMemW, nIr);
    checkOutput("sw cycles", 64'(cyc), 64'd4);
    checkOutput("sw mem_write count", 64'(nMemW), 64'd1);
    checkOutput("sw reg_write count", 64'(nReg), 64'd0);

    applyStimulus(OP_B, 0, 0, 1, cyc, nReg, nPc, nMemW, nIr);
    checkOutput("beq taken cycles", 64'(cyc), 64'd3);
    checkOutput("beq taken pc_write count", 64'(nPc), 64'd2);
    applyStimulus(OP_B, 0, 0, 0, cyc, nReg, nPc, nMemW, nIr);
    checkOutput("beq not-taken cycles", 64'(cyc), 64'd3);
    checkOutput("beq not-taken pc_write count", 64'(nPc), 64'd1);
    checkOutput("branch instret", 64'(instret), 64'd4);

    applyStimulus(OP_JALR, 0, 0, 0, cyc, nReg, nPc, nMemW, nIr);
    checkOutput("jalr cycles", 64'(cyc), 64'd5);
    checkOutput("jalr pc_write count", 64'(nPc), 64'd2);
    checkOutput("jalr reg_write count", 64'(nReg), 64'd1);
    applyStimulus(OP_JAL, 0, 0, 0, cyc, nReg, nPc, nMemW, nIr);
    checkOutput("jal cycles", 64'(cyc), 64'd4);
    checkOutput("jal reg_write count", 64'(nReg), 64'd1);

    applyStimulus(OP_LUI, 0, 0, 0, cyc, nReg, nPc, nMemW, nIr);
    checkOutput("lui cycles", 64'(cyc), 64'd4);
    applyStimulus(OP_AUIPC, 0, 0, 0, cyc, nReg, nPc, nMemW, nIr);
    checkOutput("auipc cycles", 64'(cyc), 64'd3);
    applyStimulus(OP_R, 0, 0, 0, cyc, nReg, nPc, nMemW, nIr);
    checkOutput("rtype cycles", 64'(cyc), 64'd4);
    checkOutput("instret after 9 instr", 64'(instret), 64'd9);

    op = OP_FENCE;
    memReady = 1;
    stepCycle();
    stepCycle();
    enSum = 0;
    for (int k = 0; k < 20; k++) begin
      memReady = 1'($urandom_range(0, 1));
      #1;
      enSum += int'(pcWrite) + int'(irWrite) + int'(memRead) + int'(memWrite) + int'(regWrite);
      stepCycle();
    end
    checkOutput("trap enables", 64'(enSum), 64'd0);
    checkOutput("trap state_o", 64'(stateO), 64'd14);
    checkOutput("trap illegal", 64'(illegalInstr), 64'd1);
    checkOutput("trap instret", 64'(instret), 64'd9);
    reset_n = 0;
    #1;
    checkOutput("trap reset state_o", 64'(stateO), 64'd0);
    checkOutput("trap reset illegal", 64'(illegalInstr), 64'd0);
    stepCycle();
    reset_n = 1;
    stepCycle();

    for (int k = 0; k < 17; k++) applyStimulus(OP_I, 0, 0, 0, cyc, nReg, nPc, nMemW, nIr);
    checkOutput("instret wrap", 64'(instret), 64'd1);

    op = OP_STORE;
    memReady = 1;
    stepCycle();
    stepCycle();
    stepCycle();
    memReady = 0;
    #1;
    checkOutput("memwrite active", 64'(memWrite), 64'd1);
    #1;
    reset_n = 0;
    #1;
    checkOutput("async abort mem_write", 64'(memWrite), 64'd0);
    checkOutput("async abort state_o", 64'(stateO), 64'd0);
    checkOutput("async abort instret", 64'(instret), 64'd0);
    stepCycle();
    reset_n = 1;
    stepCycle();

    trapCnt = 0;
    for (int k = 0; k < 3000; k++) begin
      if (mPhase == P_FETCH) begin
        int r = $urandom_range(0, 19);
        op = (r < 18) ? legalOps[r % 9] : ((r == 18) ? OP_FENCE : 7'b1110011);
      end
      memReady = ($urandom_range(0, 3) != 0);
      branchTaken = 1'($urandom_range(0, 1));
      if (mPhase == P_TRAP) trapCnt++;
      if (trapCnt > 4 || $urandom_range(0, 199) == 0) begin
        trapCnt = 0;
        reset_n = 0;
        #2;
        reset_n = 1;
      end
      stepCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Moore-style control FSM for the multicycle RV32I datapath, which shares one ALU and one unified instruction/data memory. It steps each instruction through fetch, decode, execute, memory and writeback, and drives every mux select and write enable. It stalls on a memory ready handshake, traps on unsupported opcodes, and counts retired instructions. Downstream, alu_op feeds the existing ALU decoder.

Parameters:
CNT_W, 32, width of the retired-instruction counter instret.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
op  in  7  opcode field from the instruction register; valid from DECODE onward.
branch_taken  in  1  branch condition result from the ALU/compare unit.
mem_ready  in  1  memory completes the current read or write this cycle.
pc_write  out  1  PC load enable.
adr_src  out  1  memory address select: 0 = PC, 1 = Result.
mem_read  out  1  memory read request.
mem_write  out  1  memory write request.
ir_write  out  1  load IR and OldPC.
result_src  out  2  Result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
alu_src_a  out  2  ALU A: 00 = PC, 01 = OldPC, 10 = RD1 register.
alu_src_b  out  2  ALU B: 00 = RD2 register, 01 = ImmExt, 10 = constant 4.
alu_op  out  2  00 = add, 01 = branch compare, 10 = funct-decoded, 11 = pass B (LUI).
imm_src  out  3  000 = I/R, 001 = S, 010 = B, 011 = J, 100 = U; decoded combinationally from op in all states; 000 for unknown opcodes.
reg_write  out  1  register file write enable.
illegal_instr  out  1  sticky trap flag.
instret  out  CNT_W  retired-instruction count.
state_o  out  4  current state, for debug.

Behaviour:
- Reset (async, reset_n = 0): state = FETCH, instret = 0, illegal_instr = 0. Outputs immediately take their FETCH values. Reset asserted mid-instruction aborts it; a pending mem_write or reg_write drops in the same cycle.
- Outputs depend only on state, except: imm_src depends on op; pc_write and ir_write in FETCH are gated by mem_ready; pc_write = pc_update | (branch & branch_taken).
- Unlisted outputs are 0 in every state. The alu_src_a value in LUI is a don't-care; drive 00.
- FETCH: adr_src = 0, mem_read = 1, alu_src_a = 00, alu_src_b = 10, alu_op = 00, result_src = 10. When mem_ready = 1: ir_write = 1, pc_update = 1, go to DECODE. Otherwise stay in FETCH with no enables.
- DECODE: alu_src_a = 01, alu_src_b = 01, alu_op = 00 (ALUOut <- OldPC + ImmExt). Next state by op:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1100011 -> BRANCH.
  - 1101111 -> JAL.
  - 1100111 -> JALR.
  - 0110111 -> LUI.
  - 0010111 -> ALUWB (ALUOut already holds OldPC + U-imm).
  - Any other op -> TRAP.
- MEMADR: alu_src_a = 10, alu_src_b = 01, alu_op = 00 -> MEMREAD if op = 0000011, else MEMWRITE.
- MEMREAD: adr_src = 1, result_src = 00, mem_read = 1. Hold until mem_ready, then -> MEMWB.
- MEMWB: result_src = 01, reg_write = 1 -> FETCH.
- MEMWRITE: adr_src = 1, result_src = 00, mem_write = 1. Hold until mem_ready, then -> FETCH.
- EXECR: alu_src_a = 10, alu_src_b = 00, alu_op = 10 -> ALUWB.
- EXECI: alu_src_a = 10, alu_src_b = 01, alu_op = 10 -> ALUWB.
- LUI: alu_src_b = 01, alu_op = 11 -> ALUWB.
- ALUWB: result_src = 00, reg_write = 1 -> FETCH.
- BRANCH: alu_src_a = 10, alu_src_b = 00, alu_op = 01, result_src = 00, branch = 1 -> FETCH. The PC loads the DECODE target only if branch_taken = 1.
- JAL: alu_src_a = 01, alu_src_b = 10, alu_op = 00, result_src = 00, pc_update = 1 (PC <- DECODE target; ALUOut <- OldPC + 4) -> ALUWB.
- JALR: alu_src_a = 10, alu_src_b = 01, alu_op = 00, result_src = 10, pc_update = 1 (PC <- rs1 + imm) -> JLINK.
- JLINK: alu_src_a = 01, alu_src_b = 10, alu_op = 00 (ALUOut <- OldPC + 4) -> ALUWB.
- TRAP: all enables 0, illegal_instr = 1. Remains in TRAP until reset.
- instret: increments by 1 on each exit to FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH. It wraps modulo 2^CNT_W and never counts a trapped instruction.
- mem_read and mem_write are never high together. mem_write is high only in MEMWRITE.
- Cycle counts with mem_ready always 1: lw 5, sw 4, R/I-type 4, branch 3, jal 4, jalr 5, lui 4, auipc 3.

Test Plan:
- lw, mem_ready low for 2 cycles in FETCH and 2 in MEMREAD -> FETCH held 3 cycles with ir_write only on the ready cycle; total 9 cycles; reg_write 1 only in MEMWB with result_src = 01; instret 0 -> 1.
- sw with mem_ready = 1 -> sequence FETCH, DECODE, MEMADR, MEMWRITE; mem_write = 1 for exactly 1 cycle with adr_src = 1; reg_write never high.
- beq with branch_taken = 1, then again with branch_taken = 0 -> pc_write pulses in BRANCH only for the first; both take 3 cycles; instret +2.
- jalr then jal -> JALR, JLINK, ALUWB sequence with pc_write in JALR (result_src = 10); jal pc_write in JAL (result_src = 00); one reg_write each.
- op = 0001111 -> TRAP after DECODE; illegal_instr = 1; zero enables for 20 cycles; instret unchanged; reset_n low -> FETCH, illegal_instr = 0.
- reset_n low mid-MEMWRITE -> mem_write falls the same cycle (async); state_o = FETCH; instret = 0. CNT_W = 4 with 17 addi -> instret = 1 (wrap).
